// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// id_ex_pipe_reg : decode->execute pipeline register with load-use bubble
//                  insertion and branch/jump flush. Optional macro:
//                  ID_EX_HAZARD_STALL_EN enables load-use detection/stall.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic            flush_i,
    input  logic [2:0]      reg_write_d,
    input  logic            alu_src_d,
    input  logic [1:0]      mem_write_d,
    input  logic [1:0]      result_src_d,
    input  logic            branch_d,
    input  logic            jump_d,
    input  logic [5:0]      alu_control_d,
    input  logic [2:0]      funct3_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    output logic            valid_e,
    output logic [2:0]      reg_write_e,
    output logic            alu_src_e,
    output logic [1:0]      mem_write_e,
    output logic [1:0]      result_src_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic [5:0]      alu_control_e,
    output logic [2:0]      funct3_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic            stall_o
);

    localparam logic [1:0] c_RESULT_LOAD = 2'b01;

    typedef struct packed {
        logic            valid;
        logic [2:0]      reg_write;
        logic            alu_src;
        logic [1:0]      mem_write;
        logic [1:0]      result_src;
        logic            branch;
        logic            jump;
        logic [5:0]      alu_control;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_word_t;

    ex_word_t ex_q;
    ex_word_t ex_d;
    ex_word_t w_dec;
    logic     w_hz;

    assign w_dec = '{valid: valid_d, reg_write: reg_write_d, alu_src: alu_src_d,
                     mem_write: mem_write_d, result_src: result_src_d,
                     branch: branch_d, jump: jump_d, alu_control: alu_control_d,
                     funct3: funct3_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d,
                     pc: pc_d, pc_plus4: pc_plus4_d, rs1: rs1_d, rs2: rs2_d,
                     rd: rd_d};

`ifdef ID_EX_HAZARD_STALL_EN
    // A load into x0 never produces a usable value, so it can never be a hazard.
    assign w_hz = ex_q.valid & (ex_q.result_src == c_RESULT_LOAD) & (ex_q.rd != 5'd0)
                & valid_d & ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d));
`else
    assign w_hz = 1'b0;
`endif

    // Flush takes priority: the held instruction is squashed anyway, so no stall.
    assign stall_o = w_hz & ~flush_i;

    always_comb begin
        ex_d = w_dec;
        if (flush_i || w_hz) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign valid_e       = ex_q.valid;
    assign reg_write_e   = ex_q.reg_write;
    assign alu_src_e     = ex_q.alu_src;
    assign mem_write_e   = ex_q.mem_write;
    assign result_src_e  = ex_q.result_src;
    assign branch_e      = ex_q.branch;
    assign jump_e        = ex_q.jump;
    assign alu_control_e = ex_q.alu_control;
    assign funct3_e      = ex_q.funct3;
    assign rd1_e         = ex_q.rd1;
    assign rd2_e         = ex_q.rd2;
    assign imm_e         = ex_q.imm;
    assign pc_e          = ex_q.pc;
    assign pc_plus4_e    = ex_q.pc_plus4;
    assign rs1_e         = ex_q.rs1;
    assign rs2_e         = ex_q.rs2;
    assign rd_e          = ex_q.rd;

endmodule

`default_nettype wire
